// File: rtl/lane_mode_controller.sv
// Lane clock ratio sequencer: drains the TX path, flips the divider select, then
// holds the datapath until the divided clock has settled.
//
//   state  | meaning
//   IDLE   | waiting for a request; only state that accepts one
//   DRAIN  | hold asserted, waiting for tx_busy to clear (bounded)
//   SWITCH | one cycle; single_lane takes the new target
//   SETTLE | hold kept high while the divided clock settles
module lane_mode_controller #(
  parameter int INIT_SINGLE_LANE = 1,
  parameter int DRAIN_TIMEOUT    = 255,
  parameter int SETTLE_CYCLES    = 16
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic req_valid,
  input  logic req_single_lane,
  output logic req_ready,
  input  logic tx_busy,
  output logic single_lane,
  output logic hold,
  output logic switch_done,
  output logic timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_LAST  = DW'(DRAIN_TIMEOUT - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  state_t        state;
  logic [DW-1:0] drain_cnt;
  logic [SW-1:0] settle_cnt;
  logic          target;
  logic          same_pend;

  assign req_ready = (state == ST_IDLE);

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      single_lane <= 1'(INIT_SINGLE_LANE);
      hold        <= 1'b0;
      switch_done <= 1'b0;
      timeout_err <= 1'b0;
      drain_cnt   <= '0;
      settle_cnt  <= '0;
      target      <= 1'(INIT_SINGLE_LANE);
      same_pend   <= 1'b0;
    end else begin
      // A same-mode request completes one cycle after acceptance.
      switch_done <= same_pend;
      timeout_err <= 1'b0;
      same_pend   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (req_single_lane == single_lane) begin
              same_pend <= 1'b1;
            end else begin
              target    <= req_single_lane;
              hold      <= 1'b1;
              drain_cnt <= '0;
              state     <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (!tx_busy) begin
            state <= ST_SWITCH;
          end else if (drain_cnt == DRAIN_LAST) begin
            state       <= ST_IDLE;
            hold        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        ST_SWITCH: begin
          single_lane <= target;
          settle_cnt  <= '0;
          state       <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state       <= ST_IDLE;
            hold        <= 1'b0;
            switch_done <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_mode_controller.sv
// Bench for lane_mode_controller: directed scenarios plus random traffic, all
// checked against an edge-timestamp model of the switching sequence.
module tb_lane_mode_controller;

  localparam int DRAIN_TIMEOUT = 255;
  localparam int SETTLE_CYCLES = 16;

  logic clk_in = 1'b0;
  logic rst_n, req_valid, req_single_lane, tx_busy;
  logic req_ready, single_lane, hold, switch_done, timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  lane_mode_controller #(
    .INIT_SINGLE_LANE(1),
    .DRAIN_TIMEOUT(DRAIN_TIMEOUT),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_single_lane(req_single_lane),
    .req_ready(req_ready),
    .tx_busy(tx_busy),
    .single_lane(single_lane),
    .hold(hold),
    .switch_done(switch_done),
    .timeout_err(timeout_err)
  );

  always #5 clk_in = ~clk_in;

  // Model: a transaction is described by the edges at which things happen.
  int   edge_n;
  bit   m_active, m_draining, m_pend_same, m_single, m_target;
  int   m_busy_run, m_switch_edge, m_done_edge;
  bit   e_done, e_to;
  logic prev_single;
  int   sl_edge, done_edge, to_edge;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic model_edge(input bit rv, input bit rs, input bit busy, input bit rstn);
    e_done = 0;
    e_to   = 0;
    if (!rstn) begin
      m_active = 0; m_draining = 0; m_pend_same = 0; m_single = 1;
      return;
    end
    if (m_pend_same) begin
      e_done = 1;
      m_pend_same = 0;
    end
    if (m_active) begin
      if (m_draining) begin
        if (!busy) begin
          m_draining    = 0;
          m_switch_edge = edge_n + 1;
          m_done_edge   = edge_n + 1 + SETTLE_CYCLES;
        end else if (m_busy_run == DRAIN_TIMEOUT - 1) begin
          m_active = 0; m_draining = 0; e_to = 1;
        end else begin
          m_busy_run++;
        end
      end else begin
        if (edge_n == m_switch_edge) m_single = m_target;
        if (edge_n == m_done_edge) begin
          m_active = 0;
          e_done   = 1;
        end
      end
    end else if (rv) begin
      if (rs == m_single) m_pend_same = 1;
      else begin
        m_active = 1; m_draining = 1; m_busy_run = 0; m_target = rs;
      end
    end
  endtask

  task automatic step(input bit rv, input bit rs, input bit busy, input bit rstn);
    req_valid = rv; req_single_lane = rs; tx_busy = busy; rst_n = rstn;
    @(posedge clk_in);
    edge_n++;
    model_edge(rv, rs, busy, rstn);
    #1;
    chk("single_lane", 32'(single_lane), 32'(m_single));
    chk("hold", 32'(hold), 32'(m_active));
    chk("req_ready", 32'(req_ready), 32'(!m_active));
    chk("switch_done", 32'(switch_done), 32'(e_done));
    chk("timeout_err", 32'(timeout_err), 32'(e_to));
    if (single_lane !== prev_single) sl_edge = edge_n;
    if (switch_done) done_edge = edge_n;
    if (timeout_err) to_edge = edge_n;
    prev_single = single_lane;
  endtask

  task automatic mark_clear();
    sl_edge = -1000; done_edge = -1000; to_edge = -1000;
  endtask

  int e0;
  bit rv_r, rs_r, busy_r, rst_r;

  initial begin
    edge_n = 0;
    prev_single = 1'b1;
    m_target = 1; m_busy_run = 0; m_switch_edge = -1; m_done_edge = -1;
    req_valid = 0; req_single_lane = 0; tx_busy = 0; rst_n = 0;
    mark_clear();

    // 1: reset defaults
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rst_single", 32'(single_lane), 32'd1);
    chk("rst_ready", 32'(req_ready), 32'd1);
    prev_single = single_lane;

    // 2: switch to multi-lane with idle datapath
    mark_clear();
    e0 = edge_n + 1;
    step(1, 0, 0, 1);
    for (int i = 0; i < 22; i++) step(0, 0, 0, 1);
    chk("t2_switch_lat", 32'(sl_edge - e0), 32'd2);
    chk("t2_done_lat", 32'(done_edge - e0), 32'd18);

    // 3: same-mode request straight from reset
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    mark_clear();
    e0 = edge_n + 1;
    step(1, 1, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    chk("t3_done_lat", 32'(done_edge - e0), 32'd1);
    chk("t3_no_switch", 32'(sl_edge), 32'hFFFF_FC18);

    // 4: drain waits 10 busy cycles
    mark_clear();
    e0 = edge_n + 1;
    step(1, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 1);
    for (int i = 0; i < 22; i++) step(0, 0, 0, 1);
    chk("t4_switch_lat", 32'(sl_edge - e0), 32'd12);
    chk("t4_done_lat", 32'(done_edge - e0), 32'd28);
    chk("t4_no_timeout", 32'(to_edge), 32'hFFFF_FC18);

    // 5: drain timeout, then a fresh request is accepted
    mark_clear();
    e0 = edge_n + 1;
    step(1, 1, 1, 1);
    for (int i = 0; i < 260; i++) step(0, 0, 1, 1);
    chk("t5_timeout_lat", 32'(to_edge - e0), 32'd255);
    chk("t5_mode_kept", 32'(single_lane), 32'd0);
    step(1, 1, 0, 1);
    chk("t5_reaccept", 32'(hold), 32'd1);
    for (int i = 0; i < 22; i++) step(0, 0, 0, 1);

    // 6: reset mid-SETTLE after moving to multi-lane; ignored requests meanwhile
    step(0, 0, 0, 0);
    mark_clear();
    step(1, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(1, i[0], 0, 1);
    chk("t6_in_settle", 32'(single_lane), 32'd0);
    step(0, 0, 0, 0);
    chk("t6_rst_single", 32'(single_lane), 32'd1);
    mark_clear();
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1);
    chk("t6_no_done", 32'(done_edge), 32'hFFFF_FC18);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rv_r   = ($urandom_range(0, 3) == 0);
      rs_r   = $urandom_range(0, 1);
      busy_r = ($urandom_range(0, 2) != 0);
      rst_r  = ($urandom_range(0, 299) != 0);
      step(rv_r, rs_r, busy_r, rst_r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
